// File: rtl/assert_status_monitor.sv
// Debug/telemetry tap beside a 4-bit data path: registers the stream, runs a wrapping
// cycle counter, flags out-of-range data, decodes the input and keeps saturating cover counts.
module assert_status_monitor #(
    parameter int CNT_MAX  = 14,
    parameter int DATA_MAX = 14,
    parameter int COV_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       data_in,
    output logic [3:0]       data_out,
    output logic [3:0]       count,
    output logic             data_changed,
    output logic             range_err,
    output logic [3:0]       lo2_onehot,
    output logic [4:0]       u0_hit,
    output logic             u0_other,
    output logic [1:0]       prio_idx,
    output logic             prio_valid,
    output logic [COV_W-1:0] cov_a_cnt,
    output logic [COV_W-1:0] cov_b_cnt
);

    localparam logic [3:0] CNT_TC   = 4'(CNT_MAX);
    localparam logic [3:0] DATA_TOP = 4'(DATA_MAX);

    logic cov_a_cond;
    logic cov_b_cond;

    assign cov_a_cond = (data_in == 4'hA);
    assign cov_b_cond = (count == 4'd8);

    // >= rather than == so a corrupted count above the terminal value recovers to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= 4'd0;
            count     <= 4'd0;
            range_err <= 1'b0;
            cov_a_cnt <= '0;
            cov_b_cnt <= '0;
        end else begin
            data_out <= data_in;
            count    <= (count >= CNT_TC) ? 4'd0 : count + 4'd1;
            if (data_in > DATA_TOP)
                range_err <= 1'b1;
            if (cov_a_cond && (cov_a_cnt != '1))
                cov_a_cnt <= cov_a_cnt + 1'b1;
            if (cov_b_cond && (cov_b_cnt != '1))
                cov_b_cnt <= cov_b_cnt + 1'b1;
        end
    end

    assign data_changed = (data_in != data_out);
    assign lo2_onehot   = 4'b0001 << data_in[1:0];
    assign u0_other     = ~|u0_hit;
    assign prio_valid   = |data_in;

    always_comb begin
        u0_hit = 5'b00000;
        case (data_in)
            4'd0:    u0_hit = 5'b00001;
            4'd1:    u0_hit = 5'b00010;
            4'd2:    u0_hit = 5'b00100;
            4'd4:    u0_hit = 5'b01000;
            4'd8:    u0_hit = 5'b10000;
            default: u0_hit = 5'b00000;
        endcase
    end

    always_comb begin
        prio_idx = 2'd0;
        if (data_in[3])
            prio_idx = 2'd3;
        else if (data_in[2])
            prio_idx = 2'd2;
        else if (data_in[1])
            prio_idx = 2'd1;
    end

endmodule

// File: tb/tb_assert_status_monitor.sv
// Self-checking bench for assert_status_monitor: decode vector table plus
// directed sequences for reset, counter wrap, sticky range error and cover saturation.
module tb_assert_status_monitor;

    logic       clk;
    logic       rst;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic [3:0] count;
    logic       data_changed;
    logic       range_err;
    logic [3:0] lo2_onehot;
    logic [4:0] u0_hit;
    logic       u0_other;
    logic [1:0] prio_idx;
    logic       prio_valid;
    logic [7:0] cov_a_cnt;
    logic [7:0] cov_b_cnt;

    int checks;
    int failures;

    assert_status_monitor #(.CNT_MAX(14), .DATA_MAX(14), .COV_W(8)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out), .count(count),
        .data_changed(data_changed), .range_err(range_err), .lo2_onehot(lo2_onehot),
        .u0_hit(u0_hit), .u0_other(u0_other), .prio_idx(prio_idx), .prio_valid(prio_valid),
        .cov_a_cnt(cov_a_cnt), .cov_b_cnt(cov_b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic [4:0] u0;
        logic       uo;
        logic [1:0] pi;
        logic       pv;
        logic [3:0] oh;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int exp_cnt;
        int exp_covb;

        checks   = 0;
        failures = 0;

        vecs[0] = '{4'd0,  5'b00001, 1'b0, 2'd0, 1'b0, 4'b0001};
        vecs[1] = '{4'd1,  5'b00010, 1'b0, 2'd0, 1'b1, 4'b0010};
        vecs[2] = '{4'd2,  5'b00100, 1'b0, 2'd1, 1'b1, 4'b0100};
        vecs[3] = '{4'd3,  5'b00000, 1'b1, 2'd1, 1'b1, 4'b1000};
        vecs[4] = '{4'd4,  5'b01000, 1'b0, 2'd2, 1'b1, 4'b0001};
        vecs[5] = '{4'd5,  5'b00000, 1'b1, 2'd2, 1'b1, 4'b0010};
        vecs[6] = '{4'd8,  5'b10000, 1'b0, 2'd3, 1'b1, 4'b0001};
        vecs[7] = '{4'd15, 5'b00000, 1'b1, 2'd3, 1'b1, 4'b1000};
        vecs[8] = '{4'd6,  5'b00000, 1'b1, 2'd2, 1'b1, 4'b0100};
        vecs[9] = '{4'd9,  5'b00000, 1'b1, 2'd3, 1'b1, 4'b0010};

        rst     = 1'b1;
        data_in = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset data_out",  32'(data_out),  32'd0);
        chk("reset count",     32'(count),     32'd0);
        chk("reset range_err", 32'(range_err), 32'd0);
        chk("reset cov_a",     32'(cov_a_cnt), 32'd0);
        chk("reset cov_b",     32'(cov_b_cnt), 32'd0);
        rst = 1'b0;

        // 32 edges: count wraps 14->0, data_out follows with one edge of latency
        exp_cnt  = 0;
        exp_covb = 0;
        for (int k = 1; k <= 32; k++) begin
            data_in = 4'(k % 8);
            @(negedge clk);
            if (exp_cnt == 8) exp_covb++;
            exp_cnt = (exp_cnt == 14) ? 0 : exp_cnt + 1;
            chk("count step", 32'(count), 32'(exp_cnt));
            chk("data_out latency", 32'(data_out), 32'(k % 8));
        end
        chk("count after 32", 32'(count), 32'd2);
        chk("cov_b after 32", 32'(cov_b_cnt), 32'd2);
        chk("cov_b model", 32'(cov_b_cnt), 32'(exp_covb));
        chk("cov_a untouched", 32'(cov_a_cnt), 32'd0);

        // sticky range error
        data_in = 4'd14;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("range_err at 14", 32'(range_err), 32'd0);
        end
        data_in = 4'd15;
        @(negedge clk);
        chk("range_err after 15", 32'(range_err), 32'd1);
        data_in = 4'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("range_err sticky", 32'(range_err), 32'd1);
        end

        // decode table
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            data_in = vecs[i].d;
            #1;
            chk("u0_hit",     32'(u0_hit),     32'(vecs[i].u0));
            chk("u0_other",   32'(u0_other),   32'(vecs[i].uo));
            chk("prio_idx",   32'(prio_idx),   32'(vecs[i].pi));
            chk("prio_valid", 32'(prio_valid), 32'(vecs[i].pv));
            chk("lo2_onehot", 32'(lo2_onehot), 32'(vecs[i].oh));
        end

        // cover A saturation, then data_changed lifetime
        @(negedge clk);
        data_in = 4'hA;
        repeat (100) @(negedge clk);
        chk("cov_a at 100", 32'(cov_a_cnt), 32'd100);
        repeat (200) @(negedge clk);
        chk("cov_a saturated", 32'(cov_a_cnt), 32'd255);
        chk("data_changed steady", 32'(data_changed), 32'd0);
        data_in = 4'd5;
        #1;
        chk("data_changed immediate", 32'(data_changed), 32'd1);
        @(posedge clk);
        #1;
        chk("data_changed after edge", 32'(data_changed), 32'd0);
        chk("data_out after change", 32'(data_out), 32'd5);
        chk("cov_a still saturated", 32'(cov_a_cnt), 32'd255);

        // async reset between edges, no clock edge needed
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async count",     32'(count),     32'd0);
        chk("async data_out",  32'(data_out),  32'd0);
        chk("async range_err", 32'(range_err), 32'd0);
        chk("async cov_a",     32'(cov_a_cnt), 32'd0);
        chk("async cov_b",     32'(cov_b_cnt), 32'd0);
        @(negedge clk);
        chk("held count", 32'(count), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("count after release", 32'(count), 32'(k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
